uart_access_arbiter: RTL
========================

Name: uart_access_arbiter

Overview:
- Arbitrates ownership of the shared UART between harts/masters through a FIFO queue of requester IDs.
- Sits behind the UART register decoder on the peripheral link and serves the REQ_ID_PUSH (0x004), GNT_ID_PEEK (0x008) and GNT_ID_POP (0x00C) registers.
- The queue head owns the UART. On release, the arbiter holds off the next grant until the TX path has drained, so bytes from two owners never interleave.
- Its output gates TX_DATA / RX_DATA accesses in the UART register block.

Parameters:
- IDW, 8, requester ID width in bits.
- DEPTH, 8, queue entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).
- TIMEOUT_CYCLES, 32'd1_000_000, idle-owner timeout; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- arst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous queue clear (UART_CTRL flush bit).
- push_i  in  1  single-cycle strobe: write to REQ_ID_PUSH.
- push_id_i  in  IDW  ID to enqueue.
- pop_i  in  1  single-cycle strobe: write to GNT_ID_POP.
- pop_id_i  in  IDW  ID releasing ownership.
- tx_idle_i  in  1  TX FIFO empty and shifter idle.
- access_i  in  1  TX_DATA/RX_DATA access strobe.
- access_id_i  in  IDW  ID of the accessing master.
- access_ok_o  out  1  combinational: access_i & gnt_valid_o & (access_id_i == gnt_id_o).
- gnt_valid_o  out  1  current owner is valid.
- gnt_id_o  out  IDW  current owner ID (the GNT_ID_PEEK value).
- count_o  out  CW  queue occupancy, including the owner.
- push_ack_o  out  1  pulse: push accepted.
- push_err_o  out  1  pulse: push rejected (full or duplicate).
- pop_err_o  out  1  pulse: pop rejected (empty or not the owner).
- timeout_o  out  1  pulse: owner evicted (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: queue empty, rd/wr pointers 0, FSM=IDLE. All outputs 0 except access_ok_o, which is combinational.
- Queue: circular buffer with IDW-bit entries. Pointers are log2(DEPTH)+1 bits; full/empty are decided from the wrap bit.
- Status pulses: push_ack_o / push_err_o / pop_err_o are registered and appear the cycle after the strobe, one cycle wide.
- Pop evaluation: pop is valid iff state==GRANTED && pop_id_i==head. Otherwise pop_err_o is asserted and the queue is unchanged.
- Push evaluation: done after the same-cycle pop has been applied. Rejected if the queue is full after that pop, or if push_id_i matches any remaining entry (duplicate).
  - Consequence: a popping owner may re-enqueue itself in the same cycle (it lands at the tail).
  - A full queue with a valid simultaneous pop accepts the push.
- FSM:
  - IDLE: gnt_valid_o=0. When count becomes nonzero, go to GRANTED on the next cycle. Grant latency from push into an empty queue: 2 cycles (ack at +1, gnt_valid_o at +2).
  - GRANTED: gnt_valid_o=1, gnt_id_o=head (registered). A valid pop dequeues the head and goes to HANDOVER.
  - HANDOVER: gnt_valid_o=0. Wait for tx_idle_i=1, then go to GRANTED if count!=0, else IDLE. A pop in HANDOVER is an error. Pushes are accepted normally.
- flush_i:
  - Empties the queue and forces IDLE next cycle.
  - Has priority over a same-cycle push/pop; those strobes are ignored, with no ack/err pulse.
  - Does not wait for tx_idle_i.
- Async reset mid-transfer: immediate return to reset state; in-flight strobes are lost.
- count_o is updated one cycle after the strobe. Simultaneous valid push and pop leaves count unchanged.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined: a 32-bit counter runs in GRANTED and is cleared on entry to GRANTED and on every access_ok_o. At TIMEOUT_CYCLES-1 the head is force-dequeued, timeout_o pulses for 1 cycle, and the FSM goes to HANDOVER.
- Undefined: no counter is built, timeout_o is tied 0, and ownership lasts until a valid pop.

Decomposition:
- hyper_titan_pkg gains:
  - uart_arb_state_e (IDLE, GRANTED, HANDOVER);
  - UART_ARB_IDW / UART_ARB_DEPTH defaults;
  - a uart_gnt_peek_t struct {valid, id} for the GNT_ID_PEEK readback.
- Sub-module uart_arb_id_fifo holds the circular buffer, pointers, and the parallel duplicate-compare vector. The top level keeps the FSM, pop check, pulses and timeout.

Test Plan:
- Push 0x01 into an empty queue → push_ack_o at +1, gnt_valid_o=1 / gnt_id_o=0x01 at +2, count_o=1.
- Push 0x01, 0x02, 0x03; pop 0x02 → pop_err_o pulse, owner remains 0x01. Pop 0x01 with tx_idle_i=0 for 5 cycles → gnt_valid_o=0 for those cycles, then gnt_id_o=0x02.
- Fill 8 entries; push 0x09 → push_err_o. Push 0x09 in the same cycle as a valid owner pop → push_ack_o, count_o stays 8.
- Queue holds 0x04,0x05; push 0x05 → push_err_o (duplicate). Owner 0x04 pops and pushes 0x04 in the same cycle → ack; the order becomes 0x05,0x04.
- access_id_i=0x05 while owner is 0x04 → access_ok_o=0; access_id_i=0x04 → 1. flush_i with 3 entries → count_o=0, IDLE next cycle, no pulses.
- UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: owner idle 16 cycles → timeout_o pulse, next owner granted after tx_idle_i. An access at cycle 10 restarts the count.

Source files
------------

// File: rtl/hyper_titan_pkg.sv
// Shared types and defaults for the UART access arbiter.
// The optional idle-owner timeout is enabled with UART_ARB_TIMEOUT_EN.
package hyper_titan_pkg;

    localparam int unsigned UART_ARB_IDW   = 8;
    localparam int unsigned UART_ARB_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANTED  = 2'd1,
        HANDOVER = 2'd2
    } uart_arb_state_e;

    typedef struct packed {
        logic                    valid;
        logic [UART_ARB_IDW-1:0] id;
    } uart_gnt_peek_t;

endpackage

// File: rtl/uart_arb_id_fifo.sv
// Circular queue of requester IDs with a parallel duplicate-compare vector.
// full_o and dup_o describe the queue as it stands after this cycle's pop.
module uart_arb_id_fifo #(
    parameter int unsigned IDW   = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           arst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  logic [IDW-1:0] push_id_i,
    input  logic           pop_i,
    output logic [IDW-1:0] head_o,
    output logic [CW-1:0]  count_o,
    output logic           full_o,
    output logic           dup_o
);

    logic [IDW-1:0]  mem [DEPTH];
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0] match;
    logic            full_now;

    assign count_o  = CW'(wr_q - rd_q);
    assign full_now = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign full_o   = full_now && !pop_i;
    assign head_o   = mem[rd_q[AW-1:0]];
    assign dup_o    = |match;

    // An entry takes part in the compare if it is occupied and is not the head being popped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [AW-1:0] offset;
        logic          occupied;
        assign offset     = AW'(gi) - rd_q[AW-1:0];
        assign occupied   = (CW'(offset) < count_o) && !(pop_i && (offset == '0));
        assign match[gi]  = occupied && (mem[gi] == push_id_i);
    end

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_q[AW-1:0]] <= push_id_i;
    end

endmodule

// File: rtl/uart_access_arbiter.sv
// UART ownership arbiter: FIFO of requester IDs, head owns the UART, TX drain between owners.
// Define UART_ARB_TIMEOUT_EN to evict owners idle for TIMEOUT_CYCLES.
module uart_access_arbiter
    import hyper_titan_pkg::*;
#(
    parameter int unsigned IDW            = UART_ARB_IDW,
    parameter int unsigned DEPTH          = UART_ARB_DEPTH,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           arst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  logic [IDW-1:0] push_id_i,
    input  logic           pop_i,
    input  logic [IDW-1:0] pop_id_i,
    input  logic           tx_idle_i,
    input  logic           access_i,
    input  logic [IDW-1:0] access_id_i,
    output logic           access_ok_o,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic [CW-1:0]  count_o,
    output logic           push_ack_o,
    output logic           push_err_o,
    output logic           pop_err_o,
    output logic           timeout_o
);

    uart_arb_state_e state_q, state_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [IDW-1:0]  head;
    logic            full_after_pop, dup;
    logic            pop_valid, pop_apply, push_apply, tmo_fire;
    logic            push_ack_q, push_err_q, pop_err_q;

    uart_arb_id_fifo #(
        .IDW   (IDW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .flush_i   (flush_i),
        .push_i    (push_apply),
        .push_id_i (push_id_i),
        .pop_i     (pop_apply),
        .head_o    (head),
        .count_o   (count_o),
        .full_o    (full_after_pop),
        .dup_o     (dup)
    );

    assign gnt_valid_o = (state_q == GRANTED);
    assign gnt_id_o    = gnt_id_q;
    assign access_ok_o = access_i && gnt_valid_o && (access_id_i == gnt_id_q);
    assign push_ack_o  = push_ack_q;
    assign push_err_o  = push_err_q;
    assign pop_err_o   = pop_err_q;

    // Push is judged against the queue after this cycle's pop has been applied.
    assign pop_valid  = pop_i && (state_q == GRANTED) && (pop_id_i == head);
    assign pop_apply  = !flush_i && (pop_valid || tmo_fire);
    assign push_apply = !flush_i && push_i && !full_after_pop && !dup;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] tmr_q, tmr_d;
    logic        timeout_q;

    assign tmo_fire  = (state_q == GRANTED) && (tmr_q == TIMEOUT_CYCLES - 32'd1)
                       && !pop_valid && !access_ok_o;
    assign tmr_d     = ((state_q != GRANTED) || access_ok_o) ? 32'd0 : tmr_q + 32'd1;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= tmo_fire && !flush_i;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (count_o != '0) state_d = GRANTED;
            GRANTED:  if (pop_apply) state_d = HANDOVER;
            HANDOVER: if (tx_idle_i) state_d = (count_o != '0) ? GRANTED : IDLE;
            default:  state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
        // Head is stable whenever we enter or stay in GRANTED, so sample it directly.
        gnt_id_d = (state_d == GRANTED) ? head : '0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            push_ack_q <= 1'b0;
            push_err_q <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            push_ack_q <= push_apply;
            push_err_q <= push_i && !flush_i && !push_apply;
            pop_err_q  <= pop_i && !flush_i && !pop_valid;
        end
    end

endmodule
